// File: rtl/mac_pkg.sv
// Shared helpers for the streaming MAC: accumulator limits and operand extension.
package mac_pkg;

    localparam int unsigned WIDE_W     = 128;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned PROD_W     = 2 * DEF_DATA_W + 1;

    typedef logic [WIDE_W-1:0] wide_t;

    // Largest positive value of an acc_w-bit two's-complement accumulator.
    function automatic wide_t acc_max(input int unsigned acc_w);
        return (wide_t'(1) << (acc_w - 1)) - wide_t'(1);
    endfunction

    // Most negative value; its low acc_w bits are the acc_w-bit encoding.
    function automatic wide_t acc_min(input int unsigned acc_w);
        return ~acc_max(acc_w);
    endfunction

    function automatic wide_t ext_operand(input wide_t value, input int unsigned w,
                                          input logic signed_mode);
        wide_t mask;
        logic  sign;
        mask = (wide_t'(1) << w) - wide_t'(1);
        sign = |(value & (wide_t'(1) << (w - 1)));
        return (signed_mode && sign) ? (value | ~mask) : (value & mask);
    endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Fixed-latency multiplier: one registered multiply followed by a MUL_LAT-1 delay line.
module mac_mul_pipe
    import mac_pkg::*;
#(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned MUL_LAT = 3,
    localparam int unsigned PW      = 2 * DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_signed,
    input  logic              in_last,
    input  logic              in_valid,
    output logic [PW-1:0]     prod,
    output logic              last,
    output logic              valid
);

    wide_t              a_w, b_w;
    logic signed [PW-1:0] a_x, b_x, mul;
    logic               unused_hi;

    assign a_w       = ext_operand(wide_t'(a), DATA_W, in_signed);
    assign b_w       = ext_operand(wide_t'(b), DATA_W, in_signed);
    assign a_x       = a_w[PW-1:0];
    assign b_x       = b_w[PW-1:0];
    assign unused_hi = ^{a_w[WIDE_W-1:PW], b_w[WIDE_W-1:PW]};
    // PW bits hold both the unsigned and the signed full-range product exactly.
    assign mul       = a_x * b_x;

    logic [PW-1:0] prod_q  [MUL_LAT];
    logic          last_q  [MUL_LAT];
    logic          valid_q [MUL_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                prod_q[i]  <= '0;
                last_q[i]  <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else if (en) begin
            prod_q[0]  <= mul;
            last_q[0]  <= in_last;
            valid_q[0] <= in_valid;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                prod_q[i]  <= prod_q[i-1];
                last_q[i]  <= last_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign prod  = prod_q[MUL_LAT-1];
    assign last  = last_q[MUL_LAT-1];
    assign valid = valid_q[MUL_LAT-1];

endmodule

// File: rtl/mac_stream_acc.sv
// Streaming multiply-accumulate: pipelined multiply, guarded accumulator, per-frame result register.
module mac_stream_acc
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ACC_W   = 40,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned SAT_EN  = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam int unsigned PW = 2 * DATA_W + 1;
    localparam wide_t MAX_W = acc_max(ACC_W);
    localparam wide_t MIN_W = acc_min(ACC_W);
    localparam logic [ACC_W-1:0] ACC_MAX = MAX_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] ACC_MIN = MIN_W[ACC_W-1:0];

    logic             stall;
    logic [PW-1:0]    p_prod;
    logic             p_last, p_valid;
    logic [ACC_W-1:0] acc, res;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             ovf_q, beat_ovf, acc_fire;
    logic [ACC_W:0]   p_ext, sum;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    mac_mul_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .en        (in_ready),
        .a         (in_a),
        .b         (in_b),
        .in_signed (in_signed),
        .in_last   (in_last),
        .in_valid  (in_valid & in_ready),
        .prod      (p_prod),
        .last      (p_last),
        .valid     (p_valid)
    );

    // One guard bit above the accumulator: the top two sum bits disagree only on overflow.
    assign p_ext    = (ACC_W + 1)'($signed(p_prod));
    assign sum      = {acc[ACC_W-1], acc} + p_ext;
    assign beat_ovf = sum[ACC_W] ^ sum[ACC_W-1];
    assign cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
    assign acc_fire = p_valid & ~stall;

    always_comb begin
        res = sum[ACC_W-1:0];
        if (SAT_EN != 0 && beat_ovf) begin
            res = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (acc_fire && p_last) begin
                out_valid <= 1'b1;
                out_acc   <= res;
                out_count <= cnt_next;
                out_ovf   <= ovf_q | beat_ovf;
                acc       <= '0;
                cnt       <= '0;
                ovf_q     <= 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (acc_fire) begin
                    acc   <= res;
                    cnt   <= cnt_next;
                    ovf_q <= ovf_q | beat_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_acc.sv
// Scoreboard bench: saturating and wrapping instances share stimulus, each checked against an arithmetic model.
module tb_mac_stream_acc;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 40;
    localparam int unsigned ML = 3;
    localparam int unsigned CW = 6;
    localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (AW - 1));
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic [AW-1:0] acc;
        logic [CW-1:0] cnt;
        logic          ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_signed, in_last, out_ready;
    logic [DW-1:0] in_a, in_b;
    logic          s_in_ready, s_out_valid, s_out_ovf;
    logic          w_in_ready, w_out_valid, w_out_ovf;
    logic [AW-1:0] s_out_acc, w_out_acc;
    logic [CW-1:0] s_out_count, w_out_count;

    int     n_tests = 0;
    int     n_fail  = 0;
    exp_t   q_sat[$];
    exp_t   q_wrap[$];
    longint m_acc_s, m_acc_w;
    bit     m_ovf_s, m_ovf_w;
    int     m_cnt;

    always #5 clk = ~clk;

    mac_stream_acc #(.DATA_W(DW), .ACC_W(AW), .MUL_LAT(ML), .SAT_EN(1), .CNT_W(CW)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_acc(s_out_acc),
        .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    mac_stream_acc #(.DATA_W(DW), .ACC_W(AW), .MUL_LAT(ML), .SAT_EN(0), .CNT_W(CW)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_last(in_last),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_acc(w_out_acc),
        .out_count(w_out_count), .out_ovf(w_out_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0; m_cnt = 0;
    endtask

    // Exact integer product and sum, then clamp or wrap into the AW-bit range.
    task automatic model_beat(input logic [DW-1:0] a, b, input logic s, l);
        longint p, sum;
        logic [AW-1:0] lo;
        exp_t e;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({48'b0, a}) * longint'({48'b0, b});
        sum = m_acc_s + p;
        if (sum > MAXV)      begin sum = MAXV; m_ovf_s = 1; end
        else if (sum < MINV) begin sum = MINV; m_ovf_s = 1; end
        m_acc_s = sum;
        sum = m_acc_w + p;
        if (sum > MAXV || sum < MINV) m_ovf_w = 1;
        lo = sum[AW-1:0];
        m_acc_w = longint'($signed(lo));
        if (m_cnt < CNT_MAX) m_cnt++;
        if (l) begin
            e.acc = m_acc_s[AW-1:0]; e.cnt = m_cnt[CW-1:0]; e.ovf = m_ovf_s;
            q_sat.push_back(e);
            e.acc = m_acc_w[AW-1:0]; e.ovf = m_ovf_w;
            q_wrap.push_back(e);
            model_clear();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] a, b, input logic s, l);
        logic ok;
        int   n;
        in_a = a; in_b = b; in_signed = s; in_last = l; in_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = s_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (ok) model_beat(a, b, s, l);
        else begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: beat not accepted within 200 cycles");
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (s_out_valid) begin
                if (q_sat.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sat_spurious: got result %0h, expected none", s_out_acc);
                end else begin
                    e = q_sat[0];
                    check("sat_acc", 64'(s_out_acc), 64'(e.acc));
                    check("sat_count", 64'(s_out_count), 64'(e.cnt));
                    check("sat_ovf", 64'(s_out_ovf), 64'(e.ovf));
                    if (out_ready) e = q_sat.pop_front();
                end
                if (!out_ready) check("stall_in_ready", 64'(s_in_ready), 64'(0));
            end
            if (w_out_valid) begin
                if (q_wrap.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL wrap_spurious: got result %0h, expected none", w_out_acc);
                end else begin
                    e = q_wrap[0];
                    check("wrap_acc", 64'(w_out_acc), 64'(e.acc));
                    check("wrap_count", 64'(w_out_count), 64'(e.cnt));
                    check("wrap_ovf", 64'(w_out_ovf), 64'(e.ovf));
                    if (out_ready) e = q_wrap.pop_front();
                end
            end
        end
    end

    initial begin
        int  n, vcnt, first, last_c, len;
        bit  done;
        logic [DW-1:0] ra, rb;

        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_last = 0;
        out_ready = 1'b1;
        model_clear();
        tick(3);
        check("reset_out_valid", 64'(s_out_valid), 64'(0));
        check("reset_out_acc", 64'(s_out_acc), 64'(0));
        check("reset_out_count", 64'(s_out_count), 64'(0));
        rst = 1'b0;
        tick(1);
        check("reset_in_ready", 64'(s_in_ready), 64'(1));

        // Signed 4-beat dot product with latency measurement on the last beat.
        send_beat(16'd3, 16'd4, 1, 0);
        send_beat(-16'sd2, 16'd5, 1, 0);
        send_beat(16'd7, -16'sd1, 1, 0);
        send_beat(-16'sd8, -16'sd8, 1, 1);
        n = 0;
        while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", 64'(n), 64'(ML));
        check("dot_acc_const", 64'(s_out_acc), 64'(59));
        tick(3);

        // Unsigned single-term frame.
        send_beat(16'hFFFF, 16'hFFFF, 0, 1);
        tick(ML + 2);

        // Positive overflow: clamps in one instance, wraps to zero in the other.
        for (int unsigned i = 0; i < 1024; i++) send_beat(16'h8000, 16'h8000, 1, i == 1023);
        tick(ML + 2);
        // Negative overflow.
        for (int unsigned i = 0; i < 600; i++) send_beat(16'h8000, 16'h7FFF, 1, i == 599);
        tick(ML + 2);

        // Back-to-back single-term frames: one result per cycle.
        vcnt = 0; first = -1; last_c = -1;
        fork
            begin
                for (int unsigned i = 0; i < 8; i++)
                    send_beat(16'(i * 37 + 1), 16'(1000 - i * 91), 1, 1);
            end
            begin
                for (int c = 0; c < 24; c++) begin
                    @(negedge clk);
                    if (s_out_valid) begin
                        vcnt++;
                        if (first < 0) first = c;
                        last_c = c;
                    end
                end
            end
        join
        check("b2b_results", 64'(vcnt), 64'(8));
        check("b2b_contiguous", 64'(last_c - first), 64'(7));
        tick(2);

        // Backpressure: two results pending, held for 5 cycles.
        out_ready = 1'b0;
        send_beat(16'd100, 16'd200, 0, 0);
        send_beat(16'd11, -16'sd3, 1, 1);
        send_beat(-16'sd50, 16'd40, 1, 1);
        n = 0;
        while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        tick(5);
        out_ready = 1'b1;
        tick(ML + 4);

        // Reset with a pending result and two beats in flight.
        out_ready = 1'b0;
        send_beat(16'd5, 16'd5, 1, 1);
        send_beat(16'd1, 16'd1, 1, 0);
        send_beat(16'd1, 16'd1, 1, 0);
        tick(2);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(s_out_valid), 64'(0));
        check("rst_out_acc", 64'(s_out_acc), 64'(0));
        check("rst_out_count", 64'(s_out_count), 64'(0));
        check("rst_out_ovf", 64'(s_out_ovf), 64'(0));
        q_sat.delete(); q_wrap.delete(); model_clear();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        tick(1);
        check("rst_in_ready", 64'(s_in_ready), 64'(1));
        send_beat(16'd2, 16'd3, 1, 1);
        n = 0;
        while (!s_out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("post_rst_acc_const", 64'(s_out_acc), 64'(6));
        check("post_rst_count_const", 64'(s_out_count), 64'(1));
        tick(2);

        // Randomised frames under random backpressure.
        done = 0;
        fork
            begin
                for (int unsigned f = 0; f < 40; f++) begin
                    len = int'($urandom_range(1, 6));
                    for (int k = 0; k < len; k++) begin
                        ra = 16'($urandom);
                        rb = 16'($urandom);
                        if ($urandom_range(0, 7) == 0) ra = 16'h8000;
                        if ($urandom_range(0, 7) == 0) rb = 16'hFFFF;
                        send_beat(ra, rb, 1'($urandom_range(0, 1)), k == len - 1);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while ((q_sat.size() != 0 || q_wrap.size() != 0) && n < 2000) begin
            @(posedge clk); n++;
        end
        check("drain_sat", 64'(q_sat.size()), 64'(0));
        check("drain_wrap", 64'(q_wrap.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
